// File: rtl/serial_pulse_peer_if.sv
// Byte-level handshake bundle between the serial pulse peer and its host-side logic.
// The peer owns the slave side: it produces received bytes and consumes bytes to send.
interface serial_pulse_peer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overflow;
  logic       rx_frame_err;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;

  modport master (
    input  rx_data, rx_valid, rx_overflow, rx_frame_err, tx_ready, tx_busy,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_overflow, rx_frame_err, tx_ready, tx_busy,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/serial_pulse_peer.sv
// Far end of the CPU pulse-width serial link: decodes pulse widths on line_rx into a byte FIFO
// and encodes host bytes onto line_tx, MSB first, one BIT_PERIOD slot per bit.
module serial_pulse_peer #(
  parameter int BIT_PERIOD = 16,
  parameter int ONE_HIGH   = 12,
  parameter int ZERO_HIGH  = 4,
  parameter int THRESHOLD  = 8,
  parameter int MIN_PULSE  = 2,
  parameter int IDLE_GAP   = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_rx,
  output logic               line_tx,
  serial_pulse_peer_if.slave bus
);

  localparam int HW = $clog2(2 * BIT_PERIOD);
  localparam int LW = $clog2(IDLE_GAP + 1);
  localparam int SW = $clog2(BIT_PERIOD);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] HI_MAX  = HW'(2 * BIT_PERIOD - 1);
  localparam logic [HW-1:0] HI_THR  = HW'(THRESHOLD);
  localparam logic [HW-1:0] HI_MIN  = HW'(MIN_PULSE);
  localparam logic [LW-1:0] LO_MAX  = LW'(IDLE_GAP);
  localparam logic [LW-1:0] LO_LAST = LW'(IDLE_GAP - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(BIT_PERIOD - 1);
  localparam logic [SW-1:0] S_ZERO  = SW'(ZERO_HIGH);
  localparam logic [SW-1:0] S_ONE   = SW'(ONE_HIGH);

  // ---------------- RX pulse measurement ----------------
  logic          sync1, sync2, line_d;
  logic [HW-1:0] hi_cnt;
  logic [LW-1:0] lo_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rise, fall, bit_take, rx_bit, push_req, gap_hit;
  logic [7:0]    byte_next;

  assign rise      = sync2 & ~line_d;
  assign fall      = ~sync2 & line_d;
  assign bit_take  = fall && (hi_cnt >= HI_MIN);
  assign rx_bit    = (hi_cnt >= HI_THR);
  assign byte_next = {shreg[6:0], rx_bit};
  assign push_req  = bit_take && (bit_cnt == 3'd7);
  // Fires on the single cycle lo_cnt steps onto IDLE_GAP; saturation keeps it one per gap.
  assign gap_hit   = ~sync2 && ~fall && (lo_cnt == LO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1            <= 1'b0;
      sync2            <= 1'b0;
      line_d           <= 1'b0;
      hi_cnt           <= '0;
      lo_cnt           <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      bus.rx_frame_err <= 1'b0;
    end else begin
      sync1            <= line_rx;
      sync2            <= sync1;
      line_d           <= sync2;
      bus.rx_frame_err <= 1'b0;
      if (sync2) begin
        if (rise)                 hi_cnt <= HW'(1);
        else if (hi_cnt != HI_MAX) hi_cnt <= hi_cnt + 1'b1;
      end else begin
        if (fall)                 lo_cnt <= LW'(1);
        else if (lo_cnt != LO_MAX) lo_cnt <= lo_cnt + 1'b1;
      end
      if (bit_take) begin
        shreg   <= byte_next;
        bit_cnt <= bit_cnt + 1'b1;
      end else if (gap_hit && (bit_cnt != 3'd0)) begin
        bit_cnt          <= '0;
        bus.rx_frame_err <= 1'b1;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic        full, pop, do_push;
  logic [7:0]  head_n;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = bus.rx_valid && bus.rx_ready;
  assign do_push = push_req && (!full || pop);

  // Output registers load the post-update head so rx_valid never shows a popped entry.
  always_comb begin
    wr_ptr_n = do_push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    if (do_push && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0])) head_n = byte_next;
    else                                                 head_n = mem[rd_ptr_n[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= byte_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.rx_valid    <= 1'b0;
      bus.rx_data     <= '0;
      bus.rx_overflow <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr_n;
      rd_ptr          <= rd_ptr_n;
      bus.rx_valid    <= (wr_ptr_n != rd_ptr_n);
      bus.rx_data     <= head_n;
      bus.rx_overflow <= push_req && full && !pop;
    end
  end

  // ---------------- TX encoder ----------------
  typedef enum logic [0:0] {TX_IDLE, TX_SLOT} tx_state_e;

  tx_state_e     tx_state, tx_state_n;
  logic [SW-1:0] slot, slot_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          line_n;

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign bus.tx_busy  = (tx_state != TX_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    slot_n     = slot;
    bit_idx_n  = bit_idx;
    tx_sh_n    = tx_sh;
    case (tx_state)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          tx_state_n = TX_SLOT;
          tx_sh_n    = bus.tx_data;
          bit_idx_n  = 3'd7;
          slot_n     = '0;
        end
      end
      TX_SLOT: begin
        if (slot == S_LAST) begin
          if (bit_idx == 3'd0) begin
            tx_state_n = TX_IDLE;
          end else begin
            bit_idx_n = bit_idx - 1'b1;
            slot_n    = '0;
          end
        end else begin
          slot_n = slot + 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // Line level is derived from the next slot position so it lines up with the state register.
    line_n = (tx_state_n == TX_SLOT) &&
             ((slot_n < S_ZERO) || ((slot_n < S_ONE) && tx_sh_n[bit_idx_n]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      slot     <= '0;
      bit_idx  <= '0;
      tx_sh    <= '0;
      line_tx  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      slot     <= slot_n;
      bit_idx  <= bit_idx_n;
      tx_sh    <= tx_sh_n;
      line_tx  <= line_n;
    end
  end

endmodule
